// File: rtl/prim_pkg.sv
// Shared definitions for the prim_stream_* width converters.
//
// Contents:
//   stream_state_e : 1-bit IDLE/SEND encoding. The upsizer uses the same encoding.
//   clamp_cnt      : limits a lane count to the number of lanes a word actually has.
package prim_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stream_state_e;

    // A count larger than the lane count would walk idx off the end of the word.
    // Clamping it keeps idx inside 0..ratio-1.
    function automatic int clamp_cnt(input int cnt, input int ratio);
        return (cnt > ratio) ? ratio : cnt;
    endfunction

endpackage

// File: rtl/prim_stream_downsize.sv
// Ready/valid width down-converter.
// Accepts one wide word of RATIO lanes and sends its first ucnt_i lanes downstream,
// one lane per beat. It sits directly behind the 2-entry skid buffer.
//
// Parameters:
//   OUT_W     : lane width (one downstream beat)
//   RATIO     : lanes per upstream word, must be >= 2
//   LSB_FIRST : 1 = lane 0 (udat_i[OUT_W-1:0]) goes first, 0 = most significant lane first
//
// Ports:
//   clk, reset : clock; synchronous active-high reset
//   urdy_o     : upstream ready
//   uvld_i     : upstream valid
//   udat_i     : upstream word
//   ucnt_i     : number of valid lanes, counted from the first-sent lane
//   ulast_i    : word ends a packet
//   drdy_i     : downstream ready
//   dvld_o     : downstream valid
//   ddat_o     : current lane
//   dlast_o    : final lane of a word that had ulast_i set
//   busy_o     : a word is held (same as dvld_o)
module prim_stream_downsize
    import prim_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   urdy_o,
    input  logic                   uvld_i,
    input  logic [OUT_W*RATIO-1:0] udat_i,
    input  logic [CNT_W-1:0]       ucnt_i,
    input  logic                   ulast_i,
    input  logic                   drdy_i,
    output logic                   dvld_o,
    output logic [OUT_W-1:0]       ddat_o,
    output logic                   dlast_o,
    output logic                   busy_o
);

    if (RATIO < 2) begin : g_bad_ratio
        $error("prim_stream_downsize: RATIO must be >= 2");
    end

    stream_state_e          state_q, state_d;
    logic [OUT_W*RATIO-1:0] hold_dat_q;
    logic                   hold_last_q;
    logic [CNT_W-1:0]       hold_cnt_q;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic                   load;

    logic                   up_beat;
    logic                   down_beat;
    logic                   last_lane;
    logic [CNT_W-1:0]       cnt_clamped;
    logic [CNT_W-1:0]       lane_sel;
    logic [OUT_W-1:0]       lane_dat;

    assign cnt_clamped = CNT_W'(clamp_cnt(int'(ucnt_i), RATIO));

    // hold_cnt_q is at least 1 whenever we are in SEND, so the subtraction cannot underflow there.
    assign last_lane = (idx_q == hold_cnt_q - CNT_W'(1));

    assign dvld_o    = (state_q == ST_SEND);
    assign busy_o    = dvld_o;
    assign down_beat = dvld_o && drdy_i;

    // Ready is also raised while the final lane hands off.
    // This lets the next word load in the same cycle with no bubble.
    assign urdy_o    = (state_q == ST_IDLE) || (down_beat && last_lane);
    assign up_beat   = uvld_i && urdy_o;

    assign dlast_o   = dvld_o && hold_last_q && last_lane;

    always_comb begin
        if (LSB_FIRST) begin
            lane_sel = idx_q;
        end else begin
            lane_sel = CNT_W'(RATIO - 1) - idx_q;
        end
    end

    assign lane_dat = hold_dat_q[int'(lane_sel) * OUT_W +: OUT_W];

    // Drive ddat_o to zero while idle, so stale hold contents never appear on the bus.
    assign ddat_o   = dvld_o ? lane_dat : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (up_beat) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    // A zero-lane word is accepted and dropped.
                    state_d = (cnt_clamped == '0) ? ST_IDLE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (down_beat) begin
                    if (!last_lane) begin
                        idx_d = idx_q + CNT_W'(1);
                    end else if (up_beat) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = (cnt_clamped == '0) ? ST_IDLE : ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hold_dat_q  <= '0;
            hold_last_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                hold_dat_q  <= udat_i;
                hold_last_q <= ulast_i;
                hold_cnt_q  <= cnt_clamped;
            end
        end
    end

`ifdef SIMULATION
    event EventUpstreamBeat;
    event EventDownstreamBeat;

    always @(posedge clk) begin
        if (!reset && up_beat) begin
            ->EventUpstreamBeat;
        end
        if (!reset && down_beat) begin
            ->EventDownstreamBeat;
        end
    end

    // A presented lane may only go away through a handshake or a reset.
    assert property (@(posedge clk) (!reset && dvld_o && !drdy_i) |=> dvld_o);
`endif

endmodule

// File: tb/tb_prim_stream_downsize.sv
module tb_prim_stream_downsize;

    localparam int OUT_W = 8;
    localparam int RATIO = 4;
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam int IN_W  = OUT_W * RATIO;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } lane_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Instance A: LSB first, checked by the scoreboard monitor
    logic             a_urdy, a_uvld, a_ulast, a_drdy, a_dvld, a_dlast, a_busy;
    logic [IN_W-1:0]  a_udat;
    logic [CNT_W-1:0] a_ucnt;
    logic [OUT_W-1:0] a_ddat;

    // Instance B: MSB first
    logic             b_urdy, b_uvld, b_ulast, b_drdy, b_dvld, b_dlast, b_busy;
    logic [IN_W-1:0]  b_udat;
    logic [CNT_W-1:0] b_ucnt;
    logic [OUT_W-1:0] b_ddat;

    prim_stream_downsize #(.OUT_W(OUT_W), .RATIO(RATIO), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset),
        .urdy_o(a_urdy), .uvld_i(a_uvld), .udat_i(a_udat), .ucnt_i(a_ucnt), .ulast_i(a_ulast),
        .drdy_i(a_drdy), .dvld_o(a_dvld), .ddat_o(a_ddat), .dlast_o(a_dlast), .busy_o(a_busy)
    );

    prim_stream_downsize #(.OUT_W(OUT_W), .RATIO(RATIO), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset),
        .urdy_o(b_urdy), .uvld_i(b_uvld), .udat_i(b_udat), .ucnt_i(b_ucnt), .ulast_i(b_ulast),
        .drdy_i(b_drdy), .dvld_o(b_dvld), .ddat_o(b_ddat), .dlast_o(b_dlast), .busy_o(b_busy)
    );

    lane_t sb_q[$];
    int checks     = 0;
    int passes     = 0;
    int beats_seen = 0;

    // Scoreboard for instance A.
    // Lanes are pushed when a word is accepted and popped when a lane is handed off.
    // The queue only ever holds the lanes of the one word in flight, so its size also
    // predicts valid and ready.
    always @(negedge clk) begin : monitor_a
        lane_t exp_lane;
        lane_t new_lane;
        logic  want_dvld;
        logic  want_urdy;
        int    n;
        if (reset) begin
            sb_q.delete();
        end else begin
            want_dvld = (sb_q.size() != 0);
            want_urdy = (sb_q.size() == 0) || (a_drdy && sb_q.size() == 1);
            checks++;
            if (a_dvld !== want_dvld) $display("[TB] FAIL sb_dvld: got %b want %b", a_dvld, want_dvld);
            else passes++;
            checks++;
            if (a_urdy !== want_urdy) $display("[TB] FAIL sb_urdy: got %b want %b", a_urdy, want_urdy);
            else passes++;
            checks++;
            if (a_busy !== want_dvld) $display("[TB] FAIL sb_busy: got %b want %b", a_busy, want_dvld);
            else passes++;

            if (a_dvld && a_drdy) begin
                beats_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL sb_extra_beat: got lane %h want no beat", a_ddat);
                end else begin
                    exp_lane = sb_q.pop_front();
                    checks++;
                    if (a_ddat !== exp_lane.data) $display("[TB] FAIL sb_ddat: got %h want %h", a_ddat, exp_lane.data);
                    else passes++;
                    checks++;
                    if (a_dlast !== exp_lane.last) $display("[TB] FAIL sb_dlast: got %b want %b", a_dlast, exp_lane.last);
                    else passes++;
                end
            end

            if (a_uvld && a_urdy) begin
                n = (int'(a_ucnt) > RATIO) ? RATIO : int'(a_ucnt);
                for (int k = 0; k < n; k++) begin
                    new_lane.data = a_udat[k*OUT_W +: OUT_W];
                    new_lane.last = a_ulast && (k == n - 1);
                    sb_q.push_back(new_lane);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        a_uvld = 1'b1;
        a_udat = 32'hDEADBEEF;
        a_ucnt = CNT_W'(4);
        a_ulast = 1'b1;
        a_drdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_urdy !== 1'b1) $display("[TB] FAIL reset_urdy: got %b want 1", a_urdy); else passes++;
        checks++;
        if (a_dvld !== 1'b0) $display("[TB] FAIL reset_dvld: got %b want 0", a_dvld); else passes++;
        checks++;
        if (a_dlast !== 1'b0) $display("[TB] FAIL reset_dlast: got %b want 0", a_dlast); else passes++;
        checks++;
        if (a_ddat !== 8'h00) $display("[TB] FAIL reset_ddat: got %h want 00", a_ddat); else passes++;
        tick();
        reset  = 1'b0;
        a_uvld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_dvld !== 1'b0) $display("[TB] FAIL reset_no_beat: got %b want 0", a_dvld); else passes++;
            tick();
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        a_drdy  = 1'b1;
        a_uvld  = 1'b1;
        a_udat  = 32'h44332211;
        a_ucnt  = CNT_W'(4);
        a_ulast = 1'b1;
        @(negedge clk);
        checks++;
        if (a_urdy !== 1'b1) $display("[TB] FAIL basic_urdy: got %b want 1", a_urdy); else passes++;
        tick();
        a_uvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_dvld !== 1'b1) $display("[TB] FAIL basic_dvld: got %b want 1", a_dvld); else passes++;
            checks++;
            if (a_ddat !== exp_b[i]) $display("[TB] FAIL basic_ddat: got %h want %h", a_ddat, exp_b[i]); else passes++;
            checks++;
            if (a_dlast !== (i == 3)) $display("[TB] FAIL basic_dlast: got %b want %b", a_dlast, (i == 3)); else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (a_dvld !== 1'b0) $display("[TB] FAIL basic_idle: got %b want 0", a_dvld); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        a_drdy  = 1'b1;
        a_uvld  = 1'b1;
        a_udat  = 32'hDDCCBBAA;
        a_ucnt  = CNT_W'(4);
        a_ulast = 1'b0;
        @(negedge clk);
        checks++;
        if (a_urdy !== 1'b1) $display("[TB] FAIL b2b_first_urdy: got %b want 1", a_urdy); else passes++;
        tick();
        a_udat  = 32'h04030201;
        a_ulast = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (a_dvld !== 1'b1) $display("[TB] FAIL b2b_dvld: got %b want 1", a_dvld); else passes++;
            checks++;
            if (a_ddat !== exp_b[i]) $display("[TB] FAIL b2b_ddat: got %h want %h", a_ddat, exp_b[i]); else passes++;
            checks++;
            if (a_urdy !== (i % 4 == 3)) $display("[TB] FAIL b2b_urdy: got %b want %b", a_urdy, (i % 4 == 3)); else passes++;
            checks++;
            if (a_dlast !== (i == 7)) $display("[TB] FAIL b2b_dlast: got %b want %b", a_dlast, (i == 7)); else passes++;
            tick();
            if (i == 3) a_uvld = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (a_dvld !== 1'b0) $display("[TB] FAIL b2b_idle: got %b want 0", a_dvld); else passes++;
        tick();
    endtask

    task automatic test_partial_zero();
        logic [7:0] exp_p [2] = '{8'hCC, 8'h55};
        logic [7:0] exp_c [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
        a_drdy  = 1'b1;
        // Two valid lanes: the upper lanes must never appear.
        a_uvld  = 1'b1;
        a_udat  = 32'h99EE55CC;
        a_ucnt  = CNT_W'(2);
        a_ulast = 1'b1;
        tick();
        a_uvld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (a_ddat !== exp_p[i]) $display("[TB] FAIL part_ddat: got %h want %h", a_ddat, exp_p[i]); else passes++;
            checks++;
            if (a_dlast !== (i == 1)) $display("[TB] FAIL part_dlast: got %b want %b", a_dlast, (i == 1)); else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (a_dvld !== 1'b0) $display("[TB] FAIL part_count: got %b want 0", a_dvld); else passes++;
        tick();
        // Zero lanes: accepted, nothing emitted, ready stays up.
        a_uvld = 1'b1;
        a_udat = 32'h12345678;
        a_ucnt = CNT_W'(0);
        @(negedge clk);
        checks++;
        if (a_urdy !== 1'b1) $display("[TB] FAIL zero_accept: got %b want 1", a_urdy); else passes++;
        tick();
        a_uvld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_dvld !== 1'b0) $display("[TB] FAIL zero_dvld: got %b want 0", a_dvld); else passes++;
            checks++;
            if (a_urdy !== 1'b1) $display("[TB] FAIL zero_urdy: got %b want 1", a_urdy); else passes++;
            tick();
        end
        // Oversized count is clamped to four lanes.
        a_uvld = 1'b1;
        a_udat = 32'h87654321;
        a_ucnt = CNT_W'(7);
        tick();
        a_uvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_ddat !== exp_c[i]) $display("[TB] FAIL clamp_ddat: got %h want %h", a_ddat, exp_c[i]); else passes++;
            checks++;
            if (a_dlast !== (i == 3)) $display("[TB] FAIL clamp_dlast: got %b want %b", a_dlast, (i == 3)); else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (a_dvld !== 1'b0) $display("[TB] FAIL clamp_count: got %b want 0", a_dvld); else passes++;
        tick();
    endtask

    task automatic test_backpressure();
        int         sent       = 0;
        int         cycles     = 0;
        int         exp_lanes  = 0;
        int         seen_start = beats_seen;
        logic       presenting = 1'b0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_dat   = '0;
        logic       prev_last  = 1'b0;
        while ((sent < 200 || presenting || sb_q.size() != 0) && cycles < 5000) begin
            a_drdy = ($urandom_range(0, 1) == 1);
            if (!presenting && sent < 200 && $urandom_range(0, 3) != 0) begin
                a_udat     = $urandom;
                a_ucnt     = CNT_W'($urandom_range(0, 7));
                a_ulast    = ($urandom_range(0, 1) == 1);
                a_uvld     = 1'b1;
                presenting = 1'b1;
                exp_lanes += (int'(a_ucnt) > RATIO) ? RATIO : int'(a_ucnt);
            end
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (a_dvld !== 1'b1) $display("[TB] FAIL bp_dvld_drop: got %b want 1", a_dvld); else passes++;
                checks++;
                if (a_ddat !== prev_dat) $display("[TB] FAIL bp_ddat_stable: got %h want %h", a_ddat, prev_dat); else passes++;
                checks++;
                if (a_dlast !== prev_last) $display("[TB] FAIL bp_dlast_stable: got %b want %b", a_dlast, prev_last); else passes++;
            end
            prev_stall = a_dvld && !a_drdy;
            prev_dat   = a_ddat;
            prev_last  = a_dlast;
            if (a_uvld && a_urdy) begin
                presenting = 1'b0;
                sent++;
            end
            tick();
            if (!presenting) a_uvld = 1'b0;
            cycles++;
        end
        a_uvld = 1'b0;
        a_drdy = 1'b1;
        checks++;
        if (sent != 200 || sb_q.size() != 0)
            $display("[TB] FAIL bp_drain: got %0d words sent, %0d lanes pending want 200, 0", sent, sb_q.size());
        else passes++;
        checks++;
        if (beats_seen - seen_start != exp_lanes)
            $display("[TB] FAIL bp_lane_total: got %0d want %0d", beats_seen - seen_start, exp_lanes);
        else passes++;
    endtask

    task automatic test_msb_reset();
        b_drdy  = 1'b1;
        b_uvld  = 1'b1;
        b_udat  = 32'h44332211;
        b_ucnt  = CNT_W'(4);
        b_ulast = 1'b1;
        @(negedge clk);
        checks++;
        if (b_urdy !== 1'b1) $display("[TB] FAIL msb_urdy: got %b want 1", b_urdy); else passes++;
        tick();
        b_uvld = 1'b0;
        @(negedge clk);
        checks++;
        if (b_dvld !== 1'b1 || b_ddat !== 8'h44) $display("[TB] FAIL msb_first: got %b/%h want 1/44", b_dvld, b_ddat); else passes++;
        tick();
        @(negedge clk);
        checks++;
        if (b_ddat !== 8'h33) $display("[TB] FAIL msb_second: got %h want 33", b_ddat); else passes++;
        tick();
        // Two lanes are gone. Reset now, with the third lane still waiting.
        reset  = 1'b1;
        b_drdy = 1'b0;
        @(negedge clk);
        checks++;
        if (b_dvld !== 1'b1 || b_ddat !== 8'h22) $display("[TB] FAIL msb_third_held: got %b/%h want 1/22", b_dvld, b_ddat); else passes++;
        tick();
        reset  = 1'b0;
        b_drdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_dvld !== 1'b0) $display("[TB] FAIL msb_after_reset: got %b want 0", b_dvld); else passes++;
            checks++;
            if (b_urdy !== 1'b1) $display("[TB] FAIL msb_reset_urdy: got %b want 1", b_urdy); else passes++;
            tick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        a_uvld  = 1'b0;
        a_udat  = '0;
        a_ucnt  = '0;
        a_ulast = 1'b0;
        a_drdy  = 1'b0;
        b_uvld  = 1'b0;
        b_udat  = '0;
        b_ucnt  = '0;
        b_ulast = 1'b0;
        b_drdy  = 1'b0;

        $display("[TB] starting prim_stream_downsize bench");
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial_zero();
        test_backpressure();
        test_msb_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
